// File: rtl/maips_mem_pkg.sv
// Shared types for the unified-memory port arbiter and the fetch stage.
package maips_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitAck,
    StWaitResp
  } arb_state_t;

  typedef enum logic [1:0] {
    OwnNone,
    OwnI,
    OwnD
  } arb_owner_t;

  localparam logic [31:0] ResetVector = 32'h0040_0000;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant decision between fetch and data, bounding how long fetch can be starved by data.
module mem_arb_pick #(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned CntW           = 3
) (
  input  logic            i_req_eff_i,
  input  logic            d_req_i,
  input  logic [CntW-1:0] starve_cnt_i,
  output logic            grant_i_o,
  output logic            grant_d_o,
  output logic [CntW-1:0] starve_cnt_o
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_DATA_BURST);

  always_comb begin
    grant_i_o    = 1'b0;
    grant_d_o    = 1'b0;
    starve_cnt_o = starve_cnt_i;
    if (d_req_i && (!i_req_eff_i || (starve_cnt_i < MaxCnt))) begin
      grant_d_o = 1'b1;
      if (!i_req_eff_i) begin
        starve_cnt_o = '0;
      end else if (starve_cnt_i < MaxCnt) begin
        starve_cnt_o = starve_cnt_i + CntW'(1);
      end
    end else if (i_req_eff_i) begin
      grant_i_o    = 1'b1;
      starve_cnt_o = '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one single-ported memory, one transaction in flight.
module mem_port_arbiter
  import maips_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_BURST = 4,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              m_req,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_ack,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata
);

  localparam int unsigned CntW = $clog2(MAX_DATA_BURST + 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic [CntW-1:0]   starve_q, starve_d, starve_pick;
  logic              drop_q, drop_d;
  logic              m_we_q, m_we_d;
  logic [3:0]        m_be_q, m_be_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic              i_req_eff, grant_i, grant_d;

  assign i_req_eff = i_req && !i_cancel;

  mem_arb_pick #(
    .MAX_DATA_BURST(MAX_DATA_BURST),
    .CntW          (CntW)
  ) u_pick (
    .i_req_eff_i (i_req_eff),
    .d_req_i     (d_req),
    .starve_cnt_i(starve_q),
    .grant_i_o   (grant_i),
    .grant_d_o   (grant_d),
    .starve_cnt_o(starve_pick)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    drop_d    = drop_q;
    m_we_d    = m_we_q;
    m_be_d    = m_be_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    unique case (state_q)
      StIdle: begin
        starve_d = starve_pick;
        if (grant_d) begin
          state_d   = StWaitAck;
          owner_d   = OwnD;
          m_we_d    = d_we;
          m_be_d    = d_be;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
        end else if (grant_i) begin
          state_d   = StWaitAck;
          owner_d   = OwnI;
          m_we_d    = 1'b0;
          m_be_d    = 4'b0000;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
        end
      end
      StWaitAck: begin
        if (m_ack) state_d = StWaitResp;
      end
      StWaitResp: begin
        if (m_rvalid) begin
          state_d = StIdle;
          owner_d = OwnNone;
        end
      end
      default: begin
        state_d = StIdle;
        owner_d = OwnNone;
      end
    endcase
    // A redirected fetch still finishes on the bus; only its done pulse is hidden.
    if (state_q != StIdle && owner_q == OwnI && i_cancel) drop_d = 1'b1;
    if (state_d == StIdle) drop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      owner_q   <= OwnNone;
      starve_q  <= '0;
      drop_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_be_q    <= 4'b0000;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      drop_q    <= drop_d;
      m_we_q    <= m_we_d;
      m_be_q    <= m_be_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_req   = (state_q == StWaitAck);
  assign m_we    = m_we_q;
  assign m_be    = m_be_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  assign i_done  = m_rvalid && (state_q == StWaitResp) && (owner_q == OwnI) && !drop_q && !i_cancel;
  assign d_done  = m_rvalid && (state_q == StWaitResp) && (owner_q == OwnD);
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: expected transactions are queued as requests are driven and retired per done.
module tb_mem_port_arbiter;
  import maips_mem_pkg::*;

  logic        clk, reset;
  logic        i_req, i_cancel, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack, m_rvalid;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        expect_done;
  } sb_t;

  sb_t sb[$];

  mem_port_arbiter #(.MAX_DATA_BURST(4), .ADDR_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_cancel(i_cancel),
    .i_rdata (i_rdata),
    .i_done  (i_done),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_be    (d_be),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_be    (m_be),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rvalid(m_rvalid),
    .m_rdata (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic push(input logic is_d, input logic [31:0] addr, input logic we,
                      input logic [3:0] be, input logic [31:0] wdata, input logic [31:0] rdata,
                      input logic expect_done);
    sb_t e;
    e.is_d = is_d; e.addr = addr; e.we = we; e.be = be;
    e.wdata = wdata; e.rdata = rdata; e.expect_done = expect_done;
    sb.push_back(e);
  endtask

  // Memory side of one transaction. cancel_mode: 0 none, 1 redirect in WAIT_RESP,
  // 2 redirect in the same cycle as m_rvalid.
  task automatic serve(input int ack_delay, input int resp_delay, input int cancel_mode,
                       input logic [31:0] new_addr);
    sb_t e;
    int  k;
    k = 0;
    while (!m_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (m_req !== 1'b1) begin
      bad++;
      $display("FAIL grant_timeout: m_req=%0b required 1", m_req);
      return;
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty: entries=0 required >=1");
      return;
    end
    e = sb.pop_front();
    total++;
    if (m_addr !== e.addr || m_we !== e.we || m_be !== e.be || (e.we && m_wdata !== e.wdata)) begin
      bad++;
      $display("FAIL grant_fields: got addr=%h we=%0b be=%b wdata=%h required addr=%h we=%0b be=%b wdata=%h",
               m_addr, m_we, m_be, m_wdata, e.addr, e.we, e.be, e.wdata);
    end
    for (int j = 0; j < ack_delay; j++) begin
      m_ack = 1'b0;
      @(negedge clk);
      total++;
      if (m_req !== 1'b1 || m_addr !== e.addr || m_we !== e.we || m_be !== e.be) begin
        bad++;
        $display("FAIL hold_stable: got req=%0b addr=%h we=%0b be=%b required req=1 addr=%h we=%0b be=%b",
                 m_req, m_addr, m_we, m_be, e.addr, e.we, e.be);
      end
    end
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    total++;
    if (m_req !== 1'b0) begin
      bad++;
      $display("FAIL req_drop: m_req=%0b required 0", m_req);
    end
    for (int j = 0; j < resp_delay; j++) begin
      if (j == 0 && cancel_mode == 1) begin
        i_cancel = 1'b1;
        i_addr   = new_addr;
      end
      @(negedge clk);
      i_cancel = 1'b0;
    end
    if (cancel_mode == 2) begin
      i_cancel = 1'b1;
      i_addr   = new_addr;
    end
    m_rvalid = 1'b1;
    m_rdata  = e.rdata;
    #1;
    total++;
    if (i_done !== (!e.is_d && e.expect_done) || d_done !== e.is_d) begin
      bad++;
      $display("FAIL done: got i_done=%0b d_done=%0b required i_done=%0b d_done=%0b",
               i_done, d_done, (!e.is_d && e.expect_done), e.is_d);
    end
    total++;
    if (e.is_d ? (d_rdata !== e.rdata) : (i_rdata !== e.rdata)) begin
      bad++;
      $display("FAIL rdata: got i=%h d=%h required %h", i_rdata, d_rdata, e.rdata);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    i_cancel = 1'b0;
    #1;
    total++;
    if (i_done !== 1'b0 || d_done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: got i_done=%0b d_done=%0b required 0 0", i_done, d_done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0; i_cancel = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    m_ack = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    total++;
    if (m_req !== 1'b0 || m_we !== 1'b0 || m_be !== 4'b0 || m_addr !== 32'h0 ||
        m_wdata !== 32'h0 || i_done !== 1'b0 || d_done !== 1'b0 || dut.starve_q !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: got req=%0b we=%0b be=%b addr=%h wdata=%h idone=%0b ddone=%0b starve=%0d required all 0",
               m_req, m_we, m_be, m_addr, m_wdata, i_done, d_done, dut.starve_q);
    end
    reset = 1'b1;
  endtask

  task automatic test_fetch_only();
    test_reset();
    i_req  = 1'b1;
    i_addr = ResetVector;
    push(1'b0, ResetVector, 1'b0, 4'b0000, 32'h0, 32'h2408_0001, 1'b1);
    serve(0, 1, 0, 32'h0);
    i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (m_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_fetch: m_req=%0b required 0", m_req);
    end
  endtask

  task automatic test_burst();
    int exp_starve[6] = '{0, 1, 2, 3, 4, 0};
    test_reset();
    i_req  = 1'b1; i_addr = 32'h0040_0010;
    d_req  = 1'b1; d_we = 1'b0; d_be = 4'b1111; d_addr = 32'h1001_0000;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) push(1'b0, 32'h0040_0010, 1'b0, 4'b0000, 32'h0, 32'h1000 + g, 1'b1);
      else        push(1'b1, 32'h1001_0000, 1'b0, 4'b1111, 32'h0, 32'h1000 + g, 1'b1);
    end
    for (int g = 0; g < 6; g++) begin
      #1;
      total++;
      if (dut.starve_q !== 3'(exp_starve[g])) begin
        bad++;
        $display("FAIL starve_cnt[%0d]: got %0d required %0d", g, dut.starve_q, exp_starve[g]);
      end
      serve(0, 0, 0, 32'h0);
      if (g == 4) i_addr = 32'h0040_0014;
    end
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write();
    test_reset();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
    push(1'b1, 32'h1001_0004, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0, 1'b1);
    serve(3, 1, 0, 32'h0);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cancel();
    test_reset();
    i_req = 1'b1; i_addr = 32'h0040_0008;
    push(1'b0, 32'h0040_0008, 1'b0, 4'b0000, 32'h0, 32'h0000_0011, 1'b0);
    push(1'b0, 32'h0040_0100, 1'b0, 4'b0000, 32'h0, 32'h0000_0022, 1'b1);
    push(1'b0, 32'h0040_0100, 1'b0, 4'b0000, 32'h0, 32'h0000_0033, 1'b0);
    push(1'b0, 32'h0040_0204, 1'b0, 4'b0000, 32'h0, 32'h0000_0044, 1'b1);
    serve(0, 1, 1, 32'h0040_0100);
    serve(0, 0, 0, 32'h0);
    serve(0, 0, 2, 32'h0040_0204);
    serve(0, 1, 0, 32'h0);
    i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cancel_idle();
    test_reset();
    i_req = 1'b1; i_cancel = 1'b1; i_addr = 32'h0040_0300;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (m_req !== 1'b0) begin
      bad++;
      $display("FAIL cancel_masks_req: m_req=%0b required 0", m_req);
    end
    i_cancel = 1'b0;
    push(1'b0, 32'h0040_0300, 1'b0, 4'b0000, 32'h0, 32'h0000_0055, 1'b1);
    serve(0, 0, 0, 32'h0);
    i_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    test_reset();
    i_req = 1'b1; i_addr = ResetVector;
    @(negedge clk);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (m_req !== 1'b0 || dut.state_q !== StIdle || m_addr !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: got req=%0b state=%0d addr=%h required 0 0 0",
               m_req, dut.state_q, m_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    i_req = 1'b0;
    m_rvalid = 1'b1;
    m_rdata = 32'hBAD0_0BAD;
    #1;
    total++;
    if (i_done !== 1'b0 || d_done !== 1'b0) begin
      bad++;
      $display("FAIL stale_rvalid: got i_done=%0b d_done=%0b required 0 0", i_done, d_done);
    end
    @(negedge clk);
    m_rvalid = 1'b0;
    total++;
    if (m_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: m_req=%0b required 0", m_req);
    end
    i_req = 1'b1; i_addr = 32'h0040_0004;
    push(1'b0, 32'h0040_0004, 1'b0, 4'b0000, 32'h0, 32'h2408_0002, 1'b1);
    serve(1, 1, 0, 32'h0);
    i_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_burst();
    test_write();
    test_cancel();
    test_cancel_idle();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
